// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 game-key receiver: scan codes, key bit positions and frame states.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_L     = 8'h4B;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] KEY_P1_UP    = 3'd0;
    localparam logic [2:0] KEY_P1_DOWN  = 3'd1;
    localparam logic [2:0] KEY_P1_LEFT  = 3'd2;
    localparam logic [2:0] KEY_P1_RIGHT = 3'd3;
    localparam logic [2:0] KEY_P2_UP    = 3'd4;
    localparam logic [2:0] KEY_P2_DOWN  = 3'd5;
    localparam logic [2:0] KEY_P2_LEFT  = 3'd6;
    localparam logic [2:0] KEY_P2_RIGHT = 3'd7;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deframer; delivers a checked byte or an error pulse.
// Byte/error appear the cycle after the stop-bit falling-edge strobe; no backpressure (keyboard drives timing).
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    output logic       rx_err
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fe_q, fe_d;
    rx_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        rx_dat_q, rx_dat_d;
    logic              rx_vld_q, rx_vld_d;
    logic              rx_err_q, rx_err_d;

    // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fe_d   = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fe_d   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = '0;
        rx_dat_d  = rx_dat_q;
        rx_vld_d  = 1'b0;
        rx_err_d  = 1'b0;

        if (state_q != ST_IDLE && !fe_q) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                rx_err_d = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (fe_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        rx_vld_d = 1'b1;
                        rx_dat_d = shift_q;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            fe_q      <= 1'b0;
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            rx_dat_q  <= 8'h00;
            rx_vld_q  <= 1'b0;
            rx_err_q  <= 1'b0;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_data;
            dat_s2_q  <= dat_s1_q;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            fe_q      <= fe_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            rx_dat_q  <= rx_dat_d;
            rx_vld_q  <= rx_vld_d;
            rx_err_q  <= rx_err_d;
        end
    end

    assign rx_dat = rx_dat_q;
    assign rx_vld = rx_vld_q;
    assign rx_err = rx_err_q;

endmodule

// File: rtl/ps2_game_keys.sv
// PS/2 keyboard to 8 held paddle-key levels; PS2_EXTENDED_EN moves P2 onto the E0-prefixed arrow keys.
// code/keys update 2 sync + FILTER_LEN + 2 cycles after the raw stop-bit edge; no backpressure.
module ps2_game_keys
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [7:0] keys
);

    logic [7:0] rx_dat;
    logic       rx_vld, rx_err;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_dat   (rx_dat),
        .rx_vld   (rx_vld),
        .rx_err   (rx_err)
    );

    logic [7:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] keys_q, keys_d;
    logic       brk_q, brk_d;
`ifdef PS2_EXTENDED_EN
    logic       ext_q, ext_d;
`endif
    logic       km_hit;
    logic [2:0] km_idx;

    always_comb begin
        km_hit = 1'b1;
        km_idx = KEY_P1_UP;
        case (rx_dat)
            SC_W:     km_idx = KEY_P1_UP;
            SC_S:     km_idx = KEY_P1_DOWN;
            SC_A:     km_idx = KEY_P1_LEFT;
            SC_D:     km_idx = KEY_P1_RIGHT;
`ifdef PS2_EXTENDED_EN
            // Without the E0 prefix these are keypad keys and must not steer P2.
            SC_UP:    begin km_idx = KEY_P2_UP;    km_hit = ext_q; end
            SC_DOWN:  begin km_idx = KEY_P2_DOWN;  km_hit = ext_q; end
            SC_LEFT:  begin km_idx = KEY_P2_LEFT;  km_hit = ext_q; end
            SC_RIGHT: begin km_idx = KEY_P2_RIGHT; km_hit = ext_q; end
`else
            SC_I:     km_idx = KEY_P2_UP;
            SC_K:     km_idx = KEY_P2_DOWN;
            SC_J:     km_idx = KEY_P2_LEFT;
            SC_L:     km_idx = KEY_P2_RIGHT;
`endif
            default:  km_hit = 1'b0;
        endcase
    end

    always_comb begin
        code_d       = code_q;
        code_valid_d = rx_vld;
        frame_err_d  = rx_err;
        keys_d       = keys_q;
        brk_d        = brk_q;
`ifdef PS2_EXTENDED_EN
        ext_d        = ext_q;
`endif
        if (rx_err) begin
            brk_d = 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_d = 1'b0;
`endif
        end else if (rx_vld) begin
            code_d = rx_dat;
            if (rx_dat == SC_BREAK) begin
                brk_d = 1'b1;
`ifdef PS2_EXTENDED_EN
            end else if (rx_dat == SC_EXT) begin
                ext_d = 1'b1;
`endif
            end else begin
                if (km_hit) begin
                    keys_d[km_idx] = ~brk_q;
                end
                brk_d = 1'b0;
`ifdef PS2_EXTENDED_EN
                ext_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            keys_q       <= 8'h00;
            brk_q        <= 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_q        <= 1'b0;
`endif
        end else begin
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            keys_q       <= keys_d;
            brk_q        <= brk_d;
`ifdef PS2_EXTENDED_EN
            ext_q        <= ext_d;
`endif
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;
    assign keys       = keys_q;

endmodule

// File: tb/tb_ps2_game_keys.sv
// Bench for ps2_game_keys: table of frames with hand-derived key states, corner sequences, and random frames vs a key model.
module tb_ps2_game_keys;

    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] keys;

    ps2_game_keys #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .keys       (keys)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    logic [7:0] last_code = 8'h00;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (code_valid) begin
            n_valid        = n_valid + 1;
            last_code      = code;
            last_valid_cyc = cyc;
        end
        if (frame_err) begin
            n_err        = n_err + 1;
            last_err_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: held keys indexed by {extended, scan code}.
    int         key_of [logic [8:0]];
    logic [7:0] keys_m;
    bit         brk_m, ext_m;

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] k;
        if (b == 8'hF0) begin
            brk_m = 1'b1;
`ifdef PS2_EXTENDED_EN
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
`endif
        end else begin
            k = {ext_m, b};
            if (key_of.exists(k)) keys_m[key_of[k]] = !brk_m;
            brk_m = 1'b0;
            ext_m = 1'b0;
        end
    endtask

    task automatic model_clear();
        brk_m = 1'b0;
        ext_m = 1'b0;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~(^b) : (^b));
        ps2_bit(stop);
        repeat (30) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        keys_m = 8'h00;
        model_clear();
    endtask

    typedef struct {
        logic [7:0] code;
        bit         par_ok;
        bit         stop;
        logic [7:0] exp_keys;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] pool[$];

    initial begin
        int v0, e0;
        logic [7:0] b;
        bit ok, good;
        logic [7:0] k0;

        key_of[{1'b0, 8'h1D}] = 0;
        key_of[{1'b0, 8'h1B}] = 1;
        key_of[{1'b0, 8'h1C}] = 2;
        key_of[{1'b0, 8'h23}] = 3;
`ifdef PS2_EXTENDED_EN
        key_of[{1'b1, 8'h75}] = 4;
        key_of[{1'b1, 8'h72}] = 5;
        key_of[{1'b1, 8'h6B}] = 6;
        key_of[{1'b1, 8'h74}] = 7;
`else
        key_of[{1'b0, 8'h43}] = 4;
        key_of[{1'b0, 8'h42}] = 5;
        key_of[{1'b0, 8'h3B}] = 6;
        key_of[{1'b0, 8'h4B}] = 7;
`endif

        vecs.push_back('{8'h1D, 1, 1, 8'h01});
        vecs.push_back('{8'hF0, 1, 1, 8'h01});
        vecs.push_back('{8'h1D, 1, 1, 8'h00});
        vecs.push_back('{8'h1C, 1, 1, 8'h04});
        vecs.push_back('{8'h23, 1, 1, 8'h0C});
        vecs.push_back('{8'hF0, 1, 1, 8'h0C});
        vecs.push_back('{8'h1C, 1, 1, 8'h08});
        vecs.push_back('{8'h1B, 0, 1, 8'h08});
        vecs.push_back('{8'h1B, 1, 1, 8'h0A});
        vecs.push_back('{8'h1D, 1, 0, 8'h0A});
        vecs.push_back('{8'h1B, 1, 1, 8'h0A});
        vecs.push_back('{8'hF0, 1, 1, 8'h0A});
        vecs.push_back('{8'h1D, 1, 1, 8'h0A});
        vecs.push_back('{8'hF0, 0, 1, 8'h0A});
        vecs.push_back('{8'h1B, 1, 1, 8'h0A});
`ifdef PS2_EXTENDED_EN
        vecs.push_back('{8'hE0, 1, 1, 8'h0A});
        vecs.push_back('{8'h75, 1, 1, 8'h1A});
        vecs.push_back('{8'h75, 1, 1, 8'h1A});
        vecs.push_back('{8'hE0, 1, 1, 8'h1A});
        vecs.push_back('{8'hF0, 1, 1, 8'h1A});
        vecs.push_back('{8'h75, 1, 1, 8'h0A});
        vecs.push_back('{8'h6B, 1, 1, 8'h0A});
        vecs.push_back('{8'hE0, 1, 1, 8'h0A});
        vecs.push_back('{8'h6B, 1, 1, 8'h4A});
`else
        vecs.push_back('{8'h43, 1, 1, 8'h1A});
        vecs.push_back('{8'hF0, 1, 1, 8'h1A});
        vecs.push_back('{8'h43, 1, 1, 8'h0A});
        vecs.push_back('{8'h4B, 1, 1, 8'h8A});
        vecs.push_back('{8'hE0, 1, 1, 8'h8A});
        vecs.push_back('{8'h75, 1, 1, 8'h8A});
`endif

        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h43, 8'h42, 8'h3B, 8'h4B,
                 8'h75, 8'h72, 8'h6B, 8'h74, 8'hF0, 8'hF0, 8'hE0, 8'hE0};

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        keys_m   = 8'h00;
        model_clear();
        repeat (5) @(negedge clk);
        check("reset keys", keys, 0);
        check("reset code", code, 0);
        check("reset code_valid", code_valid, 0);
        check("reset frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            good = vecs[i].par_ok && vecs[i].stop;
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[i].code, vecs[i].par_ok, vecs[i].stop);
            check($sformatf("vec%0d keys", i), keys, vecs[i].exp_keys);
            check($sformatf("vec%0d valid", i), n_valid - v0, int'(good));
            check($sformatf("vec%0d err", i), n_err - e0, int'(!good));
            if (good) begin
                check($sformatf("vec%0d code", i), last_code, vecs[i].code);
                model_byte(vecs[i].code);
            end else begin
                model_clear();
            end
            if (i == 0) check("latency", last_valid_cyc - fall_cyc, 2 + FILT + 2);
        end

        // Stall mid-frame long enough to trip the timeout.
        v0 = n_valid;
        e0 = n_err;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (3 * TMO) @(negedge clk);
        check("timeout err", n_err - e0, 1);
        check("timeout valid", n_valid - v0, 0);
        check("timeout late enough", int'((last_err_cyc - fall_cyc) >= FILT + TMO), 1);
        check("timeout soon enough", int'((last_err_cyc - fall_cyc) <= FILT + TMO + 6), 1);
        model_clear();
        send_frame(8'h23, 1, 1);
        model_byte(8'h23);
        check("after timeout keys", keys, keys_m);
        check("after timeout code", last_code, 8'h23);

        // Short low pulses on ps2_clk with data low must not start a frame.
        k0 = keys;
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        ps2_data = 1'b0;
        #2 ps2_clk = 1'b0;
        #1 ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT - 3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk);
        ps2_data = 1'b1;
        check("glitch keys", keys, k0);
        check("glitch valid", n_valid - v0, 0);
        check("glitch err", n_err - e0, 0);
        send_frame(8'h1B, 1, 1);
        model_byte(8'h1B);
        check("post glitch code", last_code, 8'h1B);
        check("post glitch err", n_err - e0, 0);
        check("post glitch keys", keys, keys_m);

        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(0, pool.size() - 1)];
            if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 9) != 0);
            v0 = n_valid;
            e0 = n_err;
            send_frame(b, ok, 1);
            if (ok) model_byte(b);
            else model_clear();
            check($sformatf("rnd%0d keys", n), keys, keys_m);
            check($sformatf("rnd%0d valid", n), n_valid - v0, int'(ok));
            check($sformatf("rnd%0d err", n), n_err - e0, int'(!ok));
            if (ok) check($sformatf("rnd%0d code", n), last_code, b);
        end

        // Reset in the middle of a frame, then a clean frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        do_reset();
        check("midreset keys", keys, 0);
        check("midreset code", code, 0);
        e0 = n_err;
        v0 = n_valid;
        repeat (3 * HALF) @(negedge clk);
        send_frame(8'h1D, 1, 1);
        model_byte(8'h1D);
        check("after reset keys", keys, keys_m);
        check("after reset code", last_code, 8'h1D);
        check("after reset valid", n_valid - v0, 1);
        check("after reset err", n_err - e0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
